// File: rtl/regfile_seq_pkg.sv
// Shared opcodes and FSM state encoding for the register-file operation sequencer.
package regfile_seq_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_NOP = 3'd0;
    localparam logic [OP_W-1:0] OP_ADD = 3'd1;
    localparam logic [OP_W-1:0] OP_SUB = 3'd2;
    localparam logic [OP_W-1:0] OP_AND = 3'd3;
    localparam logic [OP_W-1:0] OP_OR  = 3'd4;
    localparam logic [OP_W-1:0] OP_XOR = 3'd5;
    localparam logic [OP_W-1:0] OP_MOV = 3'd6;
    localparam logic [OP_W-1:0] OP_LDI = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WRITE  = 3'd3,
        ST_RETIRE = 3'd4
    } seq_state_e;

endpackage

// File: rtl/regfile_seq_alu.sv
// Combinational ALU: result and carry (carry-out for ADD, not-borrow for SUB, else 0).
module regfile_seq_alu
    import regfile_seq_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    localparam logic [DATA_W:0] One = (DATA_W + 1)'(1);

    always_comb begin
        result = '0;
        carry  = 1'b0;
        unique case (op)
            OP_NOP: result = '0;
            OP_ADD: {carry, result} = {1'b0, a} + {1'b0, b};
            OP_SUB: {carry, result} = {1'b0, a} + {1'b0, ~b} + One;
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_MOV: result = a;
            OP_LDI: result = imm;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/regfile_op_sequencer.sv
// Sequences one register-to-register op at a time: accept, read, execute, write back.
// Optional flag outputs flag_z/flag_c are built when REGFILE_SEQ_FLAGS_EN is defined.
module regfile_op_sequencer
    import regfile_seq_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [OP_W-1:0]   instr_op,
    input  logic [ADDR_W-1:0] instr_dst,
    input  logic [ADDR_W-1:0] instr_srca,
    input  logic [ADDR_W-1:0] instr_srcb,
    input  logic [DATA_W-1:0] instr_imm,
    output logic [ADDR_W-1:0] rf_A_sel,
    output logic [ADDR_W-1:0] rf_B_sel,
    input  logic [DATA_W-1:0] rf_A,
    input  logic [DATA_W-1:0] rf_B,
    output logic [ADDR_W-1:0] rf_replaceSel,
    output logic [DATA_W-1:0] rf_replaceData,
    output logic              rf_we,
    output logic              busy,
    output logic              done
`ifdef REGFILE_SEQ_FLAGS_EN
    ,
    output logic              flag_z,
    output logic              flag_c
`endif
);

    seq_state_e        stateQ;
    logic [OP_W-1:0]   opQ;
    logic [ADDR_W-1:0] dstQ;
    logic [DATA_W-1:0] immQ;
    logic [DATA_W-1:0] resultQ;
    logic [DATA_W-1:0] aluResult;
    logic              aluCarry;

    regfile_seq_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op     (opQ),
        .a      (rf_A),
        .b      (rf_B),
        .imm    (immQ),
        .result (aluResult),
        .carry  (aluCarry)
    );

    assign rf_replaceSel  = dstQ;
    assign rf_replaceData = resultQ;

`ifdef REGFILE_SEQ_FLAGS_EN
    logic carryQ;
`else
    logic unusedAluCarry;
    assign unusedAluCarry = aluCarry;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ      <= ST_IDLE;
            opQ         <= OP_NOP;
            dstQ        <= '0;
            immQ        <= '0;
            resultQ     <= '0;
            rf_A_sel    <= '0;
            rf_B_sel    <= '0;
            rf_we       <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
            instr_ready <= 1'b1;
`ifdef REGFILE_SEQ_FLAGS_EN
            carryQ      <= 1'b0;
            flag_z      <= 1'b0;
            flag_c      <= 1'b0;
`endif
        end else begin
            rf_we <= 1'b0;
            done  <= 1'b0;
            unique case (stateQ)
                ST_IDLE: begin
                    if (instr_valid) begin
                        opQ         <= instr_op;
                        dstQ        <= instr_dst;
                        immQ        <= instr_imm;
                        instr_ready <= 1'b0;
                        busy        <= 1'b1;
                        if (instr_op == OP_NOP) begin
                            stateQ <= ST_RETIRE;
                            done   <= 1'b1;
                        end else if (instr_op == OP_LDI) begin
                            stateQ  <= ST_WRITE;
                            resultQ <= instr_imm;
                            rf_we   <= 1'b1;
                            done    <= 1'b1;
`ifdef REGFILE_SEQ_FLAGS_EN
                            carryQ  <= 1'b0;
`endif
                        end else begin
                            // Selects are the operand-address latch; they hold until the next op.
                            stateQ   <= ST_READ;
                            rf_A_sel <= instr_srca;
                            rf_B_sel <= instr_srcb;
                        end
                    end
                end
                ST_READ: stateQ <= ST_EXEC;
                ST_EXEC: begin
                    resultQ <= aluResult;
                    rf_we   <= 1'b1;
                    done    <= 1'b1;
                    stateQ  <= ST_WRITE;
`ifdef REGFILE_SEQ_FLAGS_EN
                    carryQ  <= aluCarry;
`endif
                end
                ST_WRITE: begin
                    stateQ      <= ST_IDLE;
                    busy        <= 1'b0;
                    instr_ready <= 1'b1;
`ifdef REGFILE_SEQ_FLAGS_EN
                    flag_z      <= (resultQ == '0);
                    flag_c      <= carryQ;
`endif
                end
                ST_RETIRE: begin
                    stateQ      <= ST_IDLE;
                    busy        <= 1'b0;
                    instr_ready <= 1'b1;
                end
                default: begin
                    stateQ      <= ST_IDLE;
                    busy        <= 1'b0;
                    instr_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Self-checking bench: behavioural 16x8 register file plus an array-based reference model.
module tb_regfile_op_sequencer;

    logic       clk;
    logic       rst;
    logic       instr_valid;
    logic       instr_ready;
    logic [2:0] instr_op;
    logic [3:0] instr_dst;
    logic [3:0] instr_srca;
    logic [3:0] instr_srcb;
    logic [7:0] instr_imm;
    logic [3:0] rf_A_sel;
    logic [3:0] rf_B_sel;
    logic [7:0] rf_A;
    logic [7:0] rf_B;
    logic [3:0] rf_replaceSel;
    logic [7:0] rf_replaceData;
    logic       rf_we;
    logic       busy;
    logic       done;
`ifdef REGFILE_SEQ_FLAGS_EN
    logic       flag_z;
    logic       flag_c;
    logic       refZ = 1'b0;
    logic       refC = 1'b0;
`endif

    int vectors = 0;
    int errors  = 0;

    logic [7:0] rfMem  [16] = '{default: 8'h00};
    logic [7:0] refMem [16] = '{default: 8'h00};

    regfile_op_sequencer #(
        .DATA_W (8),
        .ADDR_W (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_op       (instr_op),
        .instr_dst      (instr_dst),
        .instr_srca     (instr_srca),
        .instr_srcb     (instr_srcb),
        .instr_imm      (instr_imm),
        .rf_A_sel       (rf_A_sel),
        .rf_B_sel       (rf_B_sel),
        .rf_A           (rf_A),
        .rf_B           (rf_B),
        .rf_replaceSel  (rf_replaceSel),
        .rf_replaceData (rf_replaceData),
        .rf_we          (rf_we),
        .busy           (busy),
        .done           (done)
`ifdef REGFILE_SEQ_FLAGS_EN
        ,
        .flag_z         (flag_z),
        .flag_c         (flag_c)
`endif
    );

    // Register file: combinational reads, write on the clock edge ending the rf_we cycle.
    assign rf_A = rfMem[rf_A_sel];
    assign rf_B = rfMem[rf_B_sel];
    always @(posedge clk) if (rf_we) rfMem[rf_replaceSel] <= rf_replaceData;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] refResult(input logic [2:0] op, input logic [7:0] a,
                                             input logic [7:0] b, input logic [7:0] imm);
        int ia = int'(a);
        int ib = int'(b);
        case (op)
            3'd1:    return 8'((ia + ib) % 256);
            3'd2:    return 8'((ia - ib + 256) % 256);
            3'd3:    return a & b;
            3'd4:    return a | b;
            3'd5:    return a ^ b;
            3'd6:    return a;
            3'd7:    return imm;
            default: return 8'h00;
        endcase
    endfunction

    // Issues one instruction, watches six cycles after the accept edge, checks timing and data.
    task automatic runInstr(input logic [2:0] op, input logic [3:0] dst, input logic [3:0] srca,
                            input logic [3:0] srcb, input logic [7:0] imm);
        int guard = 0;
        int weCount = 0;
        int weCycle = -1;
        int doneCount = 0;
        int doneCycle = -1;
        int expCycle;
        logic [7:0] expVal;
        logic [3:0] wrSel = '0;
        logic [7:0] wrData = '0;
        while (instr_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        vectors++;
        if (instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_wait got %b want 1", instr_ready);
        end
        expVal = refResult(op, refMem[srca], refMem[srcb], imm);
        expCycle = (op == 3'd7) ? 1 : 3;
        instr_valid = 1'b1;
        instr_op    = op;
        instr_dst   = dst;
        instr_srca  = srca;
        instr_srcb  = srcb;
        instr_imm   = imm;
        @(negedge clk);
        instr_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            if (k == 1) begin
                vectors++;
                if (instr_ready !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_after_accept got ready=%b busy=%b want ready=0 busy=1",
                             instr_ready, busy);
                end
            end
            if (rf_we === 1'b1) begin
                weCount++;
                weCycle = k;
                wrSel   = rf_replaceSel;
                wrData  = rf_replaceData;
            end
            if (done === 1'b1) begin
                doneCount++;
                doneCycle = k;
            end
            @(negedge clk);
        end
        vectors++;
        if (doneCount != 1 || doneCycle != ((op == 3'd0) ? 1 : expCycle)) begin
            errors++;
            $display("FAIL done_pulse op=%0d got count=%0d cycle=%0d want count=1 cycle=%0d",
                     op, doneCount, doneCycle, (op == 3'd0) ? 1 : expCycle);
        end
        if (op == 3'd0) begin
            vectors++;
            if (weCount != 0) begin
                errors++;
                $display("FAIL nop_write got we_count=%0d want 0", weCount);
            end
        end else begin
            vectors++;
            if (weCount != 1 || weCycle != expCycle) begin
                errors++;
                $display("FAIL we_timing op=%0d got count=%0d cycle=%0d want count=1 cycle=%0d",
                         op, weCount, weCycle, expCycle);
            end
            vectors++;
            if (wrSel !== dst || wrData !== expVal) begin
                errors++;
                $display("FAIL write_port op=%0d got sel=%h data=%h want sel=%h data=%h",
                         op, wrSel, wrData, dst, expVal);
            end
            refMem[dst] = expVal;
            vectors++;
            if (rfMem[dst] !== expVal) begin
                errors++;
                $display("FAIL reg_value r%0d got %h want %h", dst, rfMem[dst], expVal);
            end
`ifdef REGFILE_SEQ_FLAGS_EN
            refZ = (expVal == 8'h00);
            if (op == 3'd1)      refC = (int'(refResult(3'd6, 8'h00, 8'h00, 8'h00)) == 0) &&
                                        (int'(wrData) < 256) && (expVal < 8'h00 ? 1'b0 : 1'b0);
            refC = 1'b0;
`endif
        end
    endtask

`ifdef REGFILE_SEQ_FLAGS_EN
    // Flag reference kept separately: carry from the operand values seen before the write.
    task automatic checkFlags(input logic expZ, input logic expC, input string name);
        vectors++;
        if (flag_z !== expZ || flag_c !== expC) begin
            errors++;
            $display("FAIL %s got z=%b c=%b want z=%b c=%b", name, flag_z, flag_c, expZ, expC);
        end
    endtask
`endif

    task automatic compareFile(input string name);
        for (int r = 0; r < 16; r++) begin
            vectors++;
            if (rfMem[r] !== refMem[r]) begin
                errors++;
                $display("FAIL %s r%0d got %h want %h", name, r, rfMem[r], refMem[r]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (instr_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || rf_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got ready=%b busy=%b done=%b we=%b want 1 0 0 0",
                     instr_ready, busy, done, rf_we);
        end
        vectors++;
        if ({rf_A_sel, rf_B_sel, rf_replaceSel, rf_replaceData} !== 20'h0) begin
            errors++;
            $display("FAIL reset_data got %h want 00000",
                     {rf_A_sel, rf_B_sel, rf_replaceSel, rf_replaceData});
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (instr_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got ready=%b busy=%b want 1 0", instr_ready, busy);
        end
    endtask

    task automatic test_ldi();
        runInstr(3'd7, 4'd0, 4'd0, 4'd0, 8'hAA);
        runInstr(3'd7, 4'd1, 4'd0, 4'd0, 8'h55);
    endtask

    task automatic test_add_sub();
        runInstr(3'd1, 4'd2, 4'd0, 4'd1, 8'h00);
`ifdef REGFILE_SEQ_FLAGS_EN
        checkFlags(1'b0, 1'b0, "flags_add_ff");
`endif
        runInstr(3'd7, 4'd3, 4'd0, 4'd0, 8'hF0);
        runInstr(3'd7, 4'd4, 4'd0, 4'd0, 8'h20);
        runInstr(3'd1, 4'd5, 4'd3, 4'd4, 8'h00);
`ifdef REGFILE_SEQ_FLAGS_EN
        checkFlags(1'b0, 1'b1, "flags_add_wrap");
`endif
        runInstr(3'd2, 4'd6, 4'd4, 4'd4, 8'h00);
`ifdef REGFILE_SEQ_FLAGS_EN
        checkFlags(1'b1, 1'b1, "flags_sub_zero");
`endif
        vectors++;
        if (rfMem[2] !== 8'hFF || rfMem[5] !== 8'h10 || rfMem[6] !== 8'h00) begin
            errors++;
            $display("FAIL arith_regs got r2=%h r5=%h r6=%h want ff 10 00",
                     rfMem[2], rfMem[5], rfMem[6]);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] r3Before = rfMem[3];
        instr_valid = 1'b1;
        instr_op = 3'd0;
        instr_dst = 4'd3;
        instr_srca = 4'd0;
        instr_srcb = 4'd0;
        instr_imm = 8'h00;
        @(negedge clk);
        vectors++;
        if (done !== 1'b1 || rf_we !== 1'b0 || instr_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_nop got done=%b we=%b ready=%b want 1 0 0", done, rf_we, instr_ready);
        end
        instr_op = 3'd5;
        instr_dst = 4'd0;
        @(negedge clk);
        vectors++;
        if (instr_ready !== 1'b1 || rf_we !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle got ready=%b we=%b done=%b want 1 0 0", instr_ready, rf_we, done);
        end
        @(negedge clk);
        instr_valid = 1'b0;
        for (int k = 3; k <= 4; k++) begin
            vectors++;
            if (instr_ready !== 1'b0 || busy !== 1'b1 || rf_we !== 1'b0) begin
                errors++;
                $display("FAIL b2b_busy k=%0d got ready=%b busy=%b we=%b want 0 1 0",
                         k, instr_ready, busy, rf_we);
            end
            @(negedge clk);
        end
        vectors++;
        if (rf_we !== 1'b1 || done !== 1'b1 || rf_replaceSel !== 4'd0 || rf_replaceData !== 8'h00)
        begin
            errors++;
            $display("FAIL b2b_xor_write got we=%b done=%b sel=%h data=%h want 1 1 0 00",
                     rf_we, done, rf_replaceSel, rf_replaceData);
        end
        @(negedge clk);
        refMem[0] = refResult(3'd5, refMem[0], refMem[0], 8'h00);
        vectors++;
        if (rfMem[0] !== 8'h00 || rfMem[3] !== r3Before) begin
            errors++;
            $display("FAIL b2b_regs got r0=%h r3=%h want 00 %h", rfMem[0], rfMem[3], r3Before);
        end
`ifdef REGFILE_SEQ_FLAGS_EN
        refZ = 1'b1;
        refC = 1'b0;
        checkFlags(refZ, refC, "flags_xor");
`endif
    endtask

    task automatic test_reset_mid_op();
        int weSeen = 0;
        runInstr(3'd7, 4'd7, 4'd0, 4'd0, 8'h3C);
        instr_valid = 1'b1;
        instr_op = 3'd1;
        instr_dst = 4'd7;
        instr_srca = 4'd1;
        instr_srcb = 4'd2;
        @(negedge clk);
        instr_valid = 1'b0;
        if (rf_we === 1'b1) weSeen++;
        @(negedge clk);
        if (rf_we === 1'b1) weSeen++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (instr_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_ctrl got ready=%b busy=%b done=%b want 1 0 0",
                     instr_ready, busy, done);
        end
        for (int k = 0; k < 4; k++) begin
            if (rf_we === 1'b1) weSeen++;
            @(negedge clk);
        end
        vectors++;
        if (weSeen != 0 || rfMem[7] !== 8'h3C) begin
            errors++;
            $display("FAIL reset_mid_write got we_seen=%0d r7=%h want 0 3c", weSeen, rfMem[7]);
        end
`ifdef REGFILE_SEQ_FLAGS_EN
        refZ = 1'b0;
        refC = 1'b0;
        checkFlags(refZ, refC, "flags_after_reset");
`endif
    endtask

    task automatic test_mov_logic();
        runInstr(3'd6, 4'd8, 4'd1, 4'd0, 8'h00);
        runInstr(3'd3, 4'd9, 4'd8, 4'd0, 8'h00);
        runInstr(3'd4, 4'd9, 4'd8, 4'd0, 8'h00);
        vectors++;
        if (rfMem[8] !== 8'h55 || rfMem[9] !== 8'h55) begin
            errors++;
            $display("FAIL mov_logic got r8=%h r9=%h want 55 55", rfMem[8], rfMem[9]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [2:0] op = 3'($urandom_range(0, 7));
            logic [3:0] d  = 4'($urandom_range(0, 15));
            logic [3:0] a  = 4'($urandom_range(0, 15));
            logic [3:0] b  = 4'($urandom_range(0, 15));
            logic [7:0] im = 8'($urandom_range(0, 255));
`ifdef REGFILE_SEQ_FLAGS_EN
            int sa = int'(refMem[a]);
            int sb = int'(refMem[b]);
            logic [7:0] ev = refResult(op, refMem[a], refMem[b], im);
`endif
            runInstr(op, d, a, b, im);
`ifdef REGFILE_SEQ_FLAGS_EN
            if (op != 3'd0) begin
                refZ = (ev == 8'h00);
                refC = (op == 3'd1) ? (sa + sb > 255) : (op == 3'd2) ? (sa >= sb) : 1'b0;
            end
            checkFlags(refZ, refC, "flags_random");
`endif
        end
        compareFile("random_file");
    endtask

    initial begin
        rst = 1'b1;
        instr_valid = 1'b0;
        instr_op = 3'd0;
        instr_dst = 4'd0;
        instr_srca = 4'd0;
        instr_srcb = 4'd0;
        instr_imm = 8'h00;
        @(negedge clk);
        test_reset();
        test_ldi();
        test_add_sub();
        test_back_to_back();
        test_reset_mid_op();
        test_mov_logic();
        test_random();
        compareFile("final_file");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
